// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a sampled VGA stream (hsync/vsync plus colour),
// qualifies timing with a SEARCH/ACQUIRE/LOCKED tracker and counts sync errors.
module vga_sync_decoder #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       pix_en,
   input  logic       horiz_sync,
   input  logic       vert_sync,
   input  logic [3:0] red,
   input  logic [3:0] green,
   input  logic [3:0] blue,
   output logic [9:0] pixel_row,
   output logic [9:0] pixel_column,
   output logic       video_on,
   output logic [3:0] red_out,
   output logic [3:0] green_out,
   output logic [3:0] blue_out,
   output logic       frame_start,
   output logic       locked,
   output logic       sync_err,
   output logic [7:0] err_count
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_OFF   = H_SYNC + H_BP;
   localparam int unsigned V_OFF   = V_SYNC + V_BP;

   localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
   localparam logic [9:0]  H_LO      = 10'(H_OFF);
   localparam logic [9:0]  H_HI      = 10'(H_OFF + H_ACTIVE);
   localparam logic [9:0]  V_LO      = 10'(V_OFF);
   localparam logic [9:0]  V_HI      = 10'(V_OFF + V_ACTIVE);
   localparam logic [9:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
   state_t state, state_next;

   logic       hs_prev, vs_prev, vs_pend;
   logic [9:0] hcnt, vcnt, hcnt_next, vcnt_next;
   logic       hs_fall, vs_fall, frame_rst;
   logic       line_err, frame_err, err_now;
   logic       in_win, fs_next;
   logic [9:0] col_next, row_next;

   // Counter and error decode, meaningful only on pix_en samples
   always_comb begin
      hs_fall   = hs_prev & ~horiz_sync;
      vs_fall   = vs_prev & ~vert_sync;
      frame_rst = hs_fall & (vs_pend | vs_fall);

      hcnt_next = hcnt;
      if (hs_fall)
         hcnt_next = '0;
      else if (hcnt != CNT_MAX)
         hcnt_next = hcnt + 10'd1;

      vcnt_next = vcnt;
      if (frame_rst)
         vcnt_next = '0;
      else if (hs_fall && vcnt != CNT_MAX)
         vcnt_next = vcnt + 10'd1;

      line_err  = (hs_fall && (({1'b0, hcnt} + 11'd1) != H_TOTAL_W)) ||
                  (hcnt_next == CNT_MAX && hcnt != CNT_MAX);
      frame_err = (frame_rst && (({1'b0, vcnt} + 11'd1) != V_TOTAL_W)) ||
                  (vcnt_next == CNT_MAX && vcnt != CNT_MAX);
      err_now   = pix_en && (state != SEARCH) && (line_err || frame_err);
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst)
         state <= SEARCH;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (pix_en) begin
         case (state)
            SEARCH:  if (frame_rst) state_next = ACQUIRE;
            ACQUIRE: begin
               if (line_err || frame_err) state_next = SEARCH;
               else if (frame_rst)        state_next = LOCKED;
            end
            LOCKED:  if (line_err || frame_err) state_next = SEARCH;
            default: state_next = SEARCH;
         endcase
      end
   end

   // Outputs are derived from next-state values so a drop out of LOCKED blanks on the same update
   always_comb begin
      in_win   = (state_next == LOCKED) &&
                 (hcnt_next >= H_LO) && (hcnt_next < H_HI) &&
                 (vcnt_next >= V_LO) && (vcnt_next < V_HI);
      col_next = in_win ? (hcnt_next - H_LO) : '0;
      row_next = in_win ? (vcnt_next - V_LO) : '0;
      fs_next  = in_win && (col_next == '0) && (row_next == '0);
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         hs_prev      <= 1'b1;
         vs_prev      <= 1'b1;
         vs_pend      <= 1'b0;
         hcnt         <= '0;
         vcnt         <= '0;
         pixel_row    <= '0;
         pixel_column <= '0;
         video_on     <= 1'b0;
         red_out      <= '0;
         green_out    <= '0;
         blue_out     <= '0;
         frame_start  <= 1'b0;
         locked       <= 1'b0;
         sync_err     <= 1'b0;
         err_count    <= '0;
      end else begin
         sync_err    <= err_now;
         frame_start <= pix_en & fs_next;
         if (pix_en) begin
            hs_prev <= horiz_sync;
            vs_prev <= vert_sync;
            if (hs_fall)
               vs_pend <= 1'b0;
            else if (vs_fall)
               vs_pend <= 1'b1;
            hcnt         <= hcnt_next;
            vcnt         <= vcnt_next;
            video_on     <= in_win;
            pixel_column <= col_next;
            pixel_row    <= row_next;
            red_out      <= in_win ? red   : '0;
            green_out    <= in_win ? green : '0;
            blue_out     <= in_win ? blue  : '0;
            locked       <= (state_next == LOCKED);
            if (err_now && err_count != '1)
               err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 hsync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 SHALL have ports (name direction width meaning): sys_clk in 1 single clock; sys_rst in 1 reset, asynchronous, active-low.
REQ-003 SHALL have: pix_en in 1 pixel strobe, one sys_clk cycle per pixel; horiz_sync in 1 active-low; vert_sync in 1 active-low; red/green/blue in 4 each, incoming pixel.
REQ-004 SHALL have: pixel_row out 10; pixel_column out 10; video_on out 1; red_out/green_out/blue_out out 4 each; frame_start out 1 pulse; locked out 1; sync_err out 1 pulse; err_count out 8.

Function
REQ-005 SHALL sample horiz_sync, vert_sync, red, green, blue only on cycles with pix_en=1; all state advances only on pix_en cycles, except reset.
REQ-006 SHALL detect hsync start as sampled 1->0 on horiz_sync and vsync start as sampled 1->0 on vert_sync.
REQ-007 SHALL keep 10-bit hcnt: set to 0 on hsync start, else increment by 1, saturating at 1023.
REQ-008 SHALL keep 10-bit vcnt: on hsync start, set to 0 if a vsync start occurred since the previous hsync start (or on the same pix_en sample), else increment by 1, saturating at 1023.
REQ-009 SHALL define H_TOTAL = sum of H params (800), V_TOTAL = sum of V params (525), H_OFF = H_SYNC+H_BP (144), V_OFF = V_SYNC+V_BP (35).
REQ-010 SHALL implement FSM states SEARCH, ACQUIRE, LOCKED; reset state SEARCH.
REQ-011 SEARCH -> ACQUIRE on the first hsync start at which vcnt is set to 0.
REQ-012 ACQUIRE -> LOCKED on the hsync start that closes a frame where every line was exactly H_TOTAL and the frame was exactly V_TOTAL lines.
REQ-013 ACQUIRE or LOCKED -> SEARCH on line error: hsync start with hcnt+1 != H_TOTAL, or hcnt reaching 1023.
REQ-014 ACQUIRE or LOCKED -> SEARCH on frame error: vcnt reset with previous frame length != V_TOTAL, or vcnt reaching 1023.
REQ-015 Line or frame error in ACQUIRE/LOCKED SHALL pulse sync_err for one sys_clk cycle and increment err_count, saturating at 255; errors in SEARCH SHALL not count; simultaneous line+frame error counts once.
REQ-016 locked SHALL be 1 exactly while the state is LOCKED.
REQ-017 video_on SHALL be 1 only when LOCKED, H_OFF <= hcnt < H_OFF+H_ACTIVE and V_OFF <= vcnt < V_OFF+V_ACTIVE.
REQ-018 While video_on: pixel_column = hcnt-H_OFF, pixel_row = vcnt-V_OFF, colour outputs = sampled red/green/blue; otherwise all these SHALL be 0.
REQ-019 All outputs SHALL be registered; output for a pixel SHALL appear on the sys_clk edge after its pix_en sample and hold until the next pix_en sample.
REQ-020 frame_start SHALL pulse for one sys_clk cycle when pixel_row=0 and pixel_column=0 are first presented with video_on=1.
REQ-021 Transition to SEARCH SHALL clear video_on and colour outputs on the same update; counters keep running.

Reset
REQ-022 On sys_rst=0, asynchronously: state SEARCH, hcnt=vcnt=0, sync samples=1, all outputs 0, err_count=0.
REQ-023 Reset release SHALL require one clean frame in ACQUIRE before locked=1; reset mid-frame discards partial frame.

Verification
REQ-024 Nominal 640x480 timing, pix_en every 4th clock, after reset -> locked=1 at end of first full frame after first vsync; next frame frame_start once; 307200 video_on pixels per frame.
REQ-025 Pixel with red=4'hA at hcnt=144+10, vcnt=35+20 -> pixel_column=10, pixel_row=20, red_out=4'hA one sys_clk after its pix_en.
REQ-026 While locked, one line of 801 pixels -> sync_err one-cycle pulse, err_count=1, locked=0, video_on=0; relock after next clean frame.
REQ-027 hsync held high 1100 pixels while locked -> error at hcnt=1023, err_count increments once, SEARCH.
REQ-028 Frame of 526 lines -> frame error, err_count+1; 300 errors -> err_count stays 255.
REQ-029 sys_rst asserted mid-active-line while locked -> all outputs 0 immediately, no clock needed; locked=0 until a complete clean frame.
